// File: rtl/scan_select_gen_if.sv
// rtl/scan_select_gen_if.sv - control and channel-address bundle between scan controller and select generator
interface scan_select_gen_if #(
    parameter int DWELL_W = 8
);
    logic               en;
    logic               hold;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         A;
    logic               valid;
    logic               wrap;

    modport master (
        output en, hold, mask, dwell,
        input  A, valid, wrap
    );

    modport slave (
        input  en, hold, mask, dwell,
        output A, valid, wrap
    );
endinterface

// File: rtl/scan_select_gen.sv
// rtl/scan_select_gen.sv - round-robin channel address generator with per-channel dwell
module scan_select_gen #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    scan_select_gen_if.slave   bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state;
    logic [1:0]         a_q;
    logic               valid_q;
    logic               wrap_q;
    logic [DWELL_W-1:0] cnt;
    logic [1:0]         nxt;
    logic [1:0]         lowest;
    logic [1:0]         idx;

    // Next enabled channel strictly after a_q, circularly; falls back to a_q itself.
    always_comb begin
        nxt = a_q;
        idx = '0;
        for (int k = 3; k >= 1; k--) begin
            idx = a_q + 2'(k);
            if (bus.mask[idx]) nxt = idx;
        end
    end

    always_comb begin
        lowest = '0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mask[i]) lowest = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wrap_q <= 1'b0;
                    cnt    <= '0;
                    if (bus.en && bus.mask != 4'b0000) begin
                        state   <= SCAN;
                        a_q     <= lowest;
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!bus.en || bus.mask == 4'b0000) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        wrap_q  <= 1'b0;
                    end else if (!bus.mask[a_q]) begin
                        // Current channel was disabled mid-dwell: leave it now, hold does not apply.
                        a_q    <= nxt;
                        cnt    <= '0;
                        wrap_q <= (nxt <= a_q);
                    end else if (bus.hold) begin
                        wrap_q <= 1'b0;
                    end else if (cnt == bus.dwell) begin
                        a_q    <= nxt;
                        cnt    <= '0;
                        wrap_q <= (nxt <= a_q);
                    end else begin
                        cnt    <= cnt + 1'b1;
                        wrap_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A     = a_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_scan_select_gen.sv
// tb/tb_scan_select_gen.sv - directed-vector bench for scan_select_gen
module tb_scan_select_gen;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   wrap_seen;

    scan_select_gen_if #(.DWELL_W(8)) bus ();

    scan_select_gen #(.DWELL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] a, input logic v, input logic w);
        check({tag, ".A"}, 32'(bus.A), 32'(a));
        check({tag, ".valid"}, 32'(bus.valid), 32'(v));
        check({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
    endtask

    logic [1:0] t2_a [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
    logic       t2_w [13] = '{0,0,0,0,0,0,0,0,0,0,0,0,1};
    logic [1:0] t3_a [6]  = '{1,3,1,3,1,3};
    logic       t3_w [6]  = '{0,0,1,0,1,0};
    logic       t4_w [9]  = '{1,0,0,0,1,0,0,0,1};

    initial begin
        // T1 reset dominates en/mask
        rst = 1'b1; bus.en = 1'b1; bus.hold = 1'b0; bus.mask = 4'b1111; bus.dwell = 8'd2;
        step();
        expect_out("t1_rst", 2'd0, 1'b0, 1'b0);
        step();
        expect_out("t1_rst_hold", 2'd0, 1'b0, 1'b0);

        // T2 full scan, dwell 2
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            expect_out($sformatf("t2_%0d", i), t2_a[i], 1'b1, t2_w[i]);
        end

        // T3 sparse mask 1010, dwell 0 (A=0 disabled -> hop to 1)
        bus.mask = 4'b1010; bus.dwell = 8'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            expect_out($sformatf("t3_%0d", i), t3_a[i], 1'b1, t3_w[i]);
        end

        // T4 single channel 2, dwell 3: hop from 3 wraps, then wrap every 4th cycle
        bus.mask = 4'b0100; bus.dwell = 8'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            expect_out($sformatf("t4_%0d", i), 2'd2, 1'b1, t4_w[i]);
        end

        // T5 mid-dwell disable then hold
        bus.en = 1'b0;
        step();
        check("t5_idle.valid", 32'(bus.valid), 32'd0);
        check("t5_idle.A", 32'(bus.A), 32'd2);
        bus.mask = 4'b1111; bus.dwell = 8'd5; bus.en = 1'b1;
        step();
        expect_out("t5_start", 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("t5_still0", 32'(bus.A), 32'd0);
        step();
        expect_out("t5_adv1", 2'd1, 1'b1, 1'b0);
        step(); step();
        bus.mask = 4'b1101;
        step();
        expect_out("t5_hop", 2'd2, 1'b1, 1'b0);
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t5_hold_%0d.A", i), 32'(bus.A), 32'd2);
        end
        bus.hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t5_run_%0d.A", i), 32'(bus.A), 32'd2);
        end
        step();
        expect_out("t5_adv3", 2'd3, 1'b1, 1'b0);

        // T6 stop / restart / reset mid-scan
        bus.mask = 4'b0100;
        step();
        expect_out("t6_hop2", 2'd2, 1'b1, 1'b1);
        bus.en = 1'b0;
        step();
        expect_out("t6_stop", 2'd2, 1'b0, 1'b0);
        bus.en = 1'b1; bus.mask = 4'b1100;
        step();
        expect_out("t6_restart", 2'd2, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        step();
        expect_out("t6_rst", 2'd0, 1'b0, 1'b0);

        // dwell lowered below cnt: count runs through all-ones before matching
        rst = 1'b0; bus.mask = 4'b0001; bus.dwell = 8'd3;
        step();
        expect_out("t7_start", 2'd0, 1'b1, 1'b0);
        step(); step();
        bus.dwell = 8'd1;
        wrap_seen = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            if (bus.wrap) wrap_seen++;
        end
        check("t7_no_early_wrap", 32'(wrap_seen), 32'd0);
        step();
        expect_out("t7_wrap", 2'd0, 1'b1, 1'b1);

        // mask==0 forces idle
        bus.mask = 4'b0000;
        step();
        expect_out("t8_mask0", 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
